// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   DEPTH-entry instruction buffer between fetch and decode. Each entry holds
//   the PC, the instruction and the destination register field (instr[11:7])
//   extracted at push time. Head outputs are read straight from registered
//   storage, so there is no combinational path from fetch inputs to decode
//   outputs.
//
// Ports
//   clk              in   clock, all state on rising edge
//   rst_n            in   asynchronous active-low reset
//   mispredict_flush in   synchronous flush of all entries
//   fetch_valid      in   fetch offers an entry
//   fetch_pc         in   PC of offered instruction        [XLEN]
//   fetch_instr      in   offered instruction              [ILEN]
//   fetch_ready      out  queue accepts an entry (= !full)
//   if_id_valid      out  head entry present (= !empty)
//   if_id_pc         out  head PC                          [XLEN]
//   if_id_instr      out  head instruction                 [ILEN]
//   if_id_rd         out  head rd field                    [5]
//   decode_ready     in   decode consumes the head
//   count            out  occupancy 0..DEPTH               [CNT_W]
//   full             out  count == DEPTH
//   empty            out  count == 0
//
// Handshake: a transfer happens on a rising edge where both valid and ready
// are high (push = fetch_valid & fetch_ready, pop = if_id_valid &
// decode_ready). Valid never depends on ready in the same cycle; fetch_ready
// is !full only, so a full queue rejects an offer even while it pops.
// -----------------------------------------------------------------------------
module fetch_queue #(
   parameter  int XLEN  = 32,
   parameter  int ILEN  = 32,
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mispredict_flush,
   input  logic             fetch_valid,
   input  logic [XLEN-1:0]  fetch_pc,
   input  logic [ILEN-1:0]  fetch_instr,
   output logic             fetch_ready,
   output logic             if_id_valid,
   output logic [XLEN-1:0]  if_id_pc,
   output logic [ILEN-1:0]  if_id_instr,
   output logic [4:0]       if_id_rd,
   input  logic             decode_ready,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   // Storage
   logic [XLEN-1:0]  r_pc_mem    [DEPTH];
   logic [ILEN-1:0]  r_instr_mem [DEPTH];
   logic [4:0]       r_rd_mem    [DEPTH];

   // Pointers wrap naturally because DEPTH is a power of two
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_push  = fetch_valid & ~w_full;
   assign w_pop   = decode_ready & ~w_empty;

   assign fetch_ready = ~w_full;
   assign if_id_valid = ~w_empty;
   assign full        = w_full;
   assign empty       = w_empty;
   assign count       = r_count;

   // Head is a plain read of storage; stale when empty
   assign if_id_pc    = r_pc_mem[r_rptr];
   assign if_id_instr = r_instr_mem[r_rptr];
   assign if_id_rd    = r_rd_mem[r_rptr];

   // Pointers and occupancy. A flush overrides any push/pop of the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (mispredict_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // Entry storage: zeroed on reset, left untouched by a flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_pc_mem[i]    <= '0;
            r_instr_mem[i] <= '0;
            r_rd_mem[i]    <= '0;
         end
      end else if (w_push && !mispredict_flush) begin
         r_pc_mem[r_wptr]    <= fetch_pc;
         r_instr_mem[r_wptr] <= fetch_instr;
         // rd is extracted regardless of opcode; decode decides if it is used
         r_rd_mem[r_wptr]    <= fetch_instr[11:7];
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

   localparam int XLEN  = 32;
   localparam int ILEN  = 32;
   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int W     = XLEN + ILEN;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             mispredict_flush = 1'b0;
   logic             fetch_valid = 1'b0;
   logic [XLEN-1:0]  fetch_pc = '0;
   logic [ILEN-1:0]  fetch_instr = '0;
   logic             fetch_ready;
   logic             if_id_valid;
   logic [XLEN-1:0]  if_id_pc;
   logic [ILEN-1:0]  if_id_instr;
   logic [4:0]       if_id_rd;
   logic             decode_ready = 1'b0;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;

   always #5 clk = ~clk;

   fetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .mispredict_flush (mispredict_flush),
      .fetch_valid      (fetch_valid),
      .fetch_pc         (fetch_pc),
      .fetch_instr      (fetch_instr),
      .fetch_ready      (fetch_ready),
      .if_id_valid      (if_id_valid),
      .if_id_pc         (if_id_pc),
      .if_id_instr      (if_id_instr),
      .if_id_rd         (if_id_rd),
      .decode_ready     (decode_ready),
      .count            (count),
      .full             (full),
      .empty            (empty)
   );

   // ---------------- scoreboard ----------------
   // Reference model: an ordered queue of {pc, instr} entries.
   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string where);
      int               sz;
      logic [W-1:0]     head;
      logic [ILEN-1:0]  hi;
      sz = exp_q.size();
      chk({where, ":count"},       64'(count),       64'(sz));
      chk({where, ":full"},        64'(full),        64'(sz == DEPTH));
      chk({where, ":empty"},       64'(empty),       64'(sz == 0));
      chk({where, ":fetch_ready"}, 64'(fetch_ready), 64'(sz != DEPTH));
      chk({where, ":valid"},       64'(if_id_valid), 64'(sz != 0));
      if (sz > 0) begin
         head = exp_q[0];
         hi   = head[ILEN-1:0];
         chk({where, ":pc"},    64'(if_id_pc),    64'(head[W-1:ILEN]));
         chk({where, ":instr"}, 64'(if_id_instr), 64'(hi));
         chk({where, ":rd"},    64'(if_id_rd),    64'(hi[11:7]));
      end
   endtask

   // ---------------- driver ----------------
   // Called just after a falling edge: drive, check the current state against
   // the model, let one rising edge happen, then advance the model.
   task automatic cycle(input string where, input logic fv, input logic [XLEN-1:0] pc,
                        input logic [ILEN-1:0] ins, input logic dr, input logic fl);
      logic do_push, do_pop;
      fetch_valid      = fv;
      fetch_pc         = pc;
      fetch_instr      = ins;
      decode_ready     = dr;
      mispredict_flush = fl;
      #1;
      check_outputs(where);
      do_push = fv && (exp_q.size() < DEPTH);
      do_pop  = dr && (exp_q.size() > 0);
      @(posedge clk);
      if (fl) begin
         exp_q.delete();
      end else begin
         if (do_pop)  void'(exp_q.pop_front());
         if (do_push) exp_q.push_back({pc, ins});
      end
      @(negedge clk);
   endtask

   task automatic idle(input string where);
      cycle(where, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      // Reset state
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst:count", 64'(count), 64'(0));
      chk("rst:empty", 64'(empty), 64'(1));
      chk("rst:valid", 64'(if_id_valid), 64'(0));
      chk("rst:full",  64'(full), 64'(0));
      chk("rst:ready", 64'(fetch_ready), 64'(1));
      chk("rst:pc",    64'(if_id_pc), 64'(0));
      rst_n = 1'b1;

      // Fill and drain in order; 5th offer rejected while full
      for (int i = 0; i < 4; i++)
         cycle("fill", 1'b1, 32'h100 + 32'(4 * i), $urandom, 1'b0, 1'b0);
      chk("fill:full", 64'(full), 64'(1));
      chk("fill:ready", 64'(fetch_ready), 64'(0));
      cycle("fifth", 1'b1, 32'h110, $urandom, 1'b0, 1'b0);
      chk("fifth:count", 64'(count), 64'(4));
      for (int i = 0; i < 4; i++) begin
         chk("drain:pc", 64'(if_id_pc), 64'(32'h100 + 32'(4 * i)));
         cycle("drain", 1'b0, '0, '0, 1'b1, 1'b0);
      end
      chk("drain:empty", 64'(empty), 64'(1));

      // Full with simultaneous pop: push rejected, accepted next cycle
      for (int i = 0; i < 4; i++)
         cycle("fill2", 1'b1, 32'h100 + 32'(4 * i), $urandom, 1'b0, 1'b0);
      cycle("fullpop", 1'b1, 32'h110, 32'h0, 1'b1, 1'b0);
      chk("fullpop:count", 64'(count), 64'(3));
      chk("fullpop:head", 64'(if_id_pc), 64'(32'h104));
      cycle("accept", 1'b1, 32'h110, 32'h0, 1'b0, 1'b0);
      chk("accept:count", 64'(count), 64'(4));
      for (int i = 0; i < 4; i++) cycle("drain2", 1'b0, '0, '0, 1'b1, 1'b0);
      chk("drain2:empty", 64'(empty), 64'(1));

      // Streaming with wrap: 10 back-to-back pushes, count stays at 1
      for (int i = 0; i < 10; i++) begin
         cycle("stream", 1'b1, 32'h400 + 32'(4 * i), $urandom, 1'b1, 1'b0);
         chk("stream:count", 64'(count), 64'(1));
         chk("stream:pc", 64'(if_id_pc), 64'(32'h400 + 32'(4 * i)));
      end
      cycle("stream_end", 1'b0, '0, '0, 1'b1, 1'b0);

      // rd extraction: addi a1,x0,10
      cycle("rd", 1'b1, 32'h200, 32'h00A00593, 1'b0, 1'b0);
      chk("rd:a1", 64'(if_id_rd), 64'(11));
      cycle("rd_pop", 1'b0, '0, '0, 1'b1, 1'b0);

      // Flush with concurrent traffic
      cycle("fl_fill", 1'b1, 32'h300, $urandom, 1'b0, 1'b0);
      cycle("fl_fill", 1'b1, 32'h304, $urandom, 1'b0, 1'b0);
      cycle("flush", 1'b1, 32'h308, $urandom, 1'b1, 1'b1);
      chk("flush:count", 64'(count), 64'(0));
      chk("flush:valid", 64'(if_id_valid), 64'(0));
      cycle("post_flush", 1'b1, 32'h500, 32'h00000F80, 1'b0, 1'b0);
      chk("post_flush:pc", 64'(if_id_pc), 64'(32'h500));
      chk("post_flush:rd", 64'(if_id_rd), 64'(31));

      // Reset mid-operation
      cycle("mr_fill", 1'b1, 32'h600, $urandom, 1'b0, 1'b0);
      cycle("mr_fill", 1'b1, 32'h604, $urandom, 1'b0, 1'b0);
      chk("mr:count3", 64'(count), 64'(3));
      fetch_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("mr:count", 64'(count), 64'(0));
      chk("mr:empty", 64'(empty), 64'(1));
      chk("mr:valid", 64'(if_id_valid), 64'(0));
      chk("mr:pc",    64'(if_id_pc), 64'(0));
      chk("mr:ready", 64'(fetch_ready), 64'(1));
      @(negedge clk);
      rst_n = 1'b1;
      cycle("mr_push", 1'b1, 32'h700, $urandom, 1'b0, 1'b0);
      chk("mr_push:pc", 64'(if_id_pc), 64'(32'h700));

      // Randomized traffic in phases with different bias
      for (int ph = 0; ph < 4; ph++) begin
         for (int i = 0; i < 100; i++) begin
            logic fv, dr, fl;
            fv = ($urandom_range(0, 3) <= 32'(3 - ph));
            dr = ($urandom_range(0, 3) <= 32'(ph));
            fl = ($urandom_range(0, 40) == 0);
            cycle("rand", fv, $urandom, $urandom, dr, fl);
         end
      end

      // Drain and final check
      for (int i = 0; i < DEPTH; i++) cycle("final", 1'b0, '0, '0, 1'b1, 1'b0);
      idle("final_idle");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction buffer between the fetch stage and decode, replacing the single-entry IF/ID register with a DEPTH-entry FIFO and a valid/ready handshake on both sides. It absorbs decode stalls without stalling cache returns, carries PC, instruction and pre-extracted destination register per entry, and supports a single-cycle mispredict flush. Output fields come straight from registered storage, so there is no combinational path from input to output.

## Interface
- XLEN, 32, width of PC field
- ILEN, 32, width of instruction field
- DEPTH, 4, number of entries; power of two, ≥ 2
- CNT_W, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- mispredict_flush  in  1  synchronous flush of all entries
- fetch_valid  in  1  fetch offers an entry this cycle
- fetch_pc  in  XLEN  PC of offered instruction
- fetch_instr  in  ILEN  offered instruction
- fetch_ready  out  1  queue accepts an entry this cycle (= !full)
- if_id_valid  out  1  head entry present (= !empty)
- if_id_pc  out  XLEN  head PC
- if_id_instr  out  ILEN  head instruction
- if_id_rd  out  5  head instruction bits [11:7], captured at push
- decode_ready  in  1  decode consumes head this cycle
- count  out  CNT_W  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Storage: DEPTH entries of {pc, instr, rd}; write pointer, read pointer (log2(DEPTH) bits, natural wrap), occupancy counter.
- push = fetch_valid & fetch_ready; pop = if_id_valid & decode_ready.
- fetch_ready = !full only; it never depends on decode_ready. When full, offered entry is not accepted even if pop occurs in the same cycle.
- push only: entry written at wptr, wptr+1, count+1. pop only: rptr+1, count−1. Both: write and read, pointers advance, count unchanged (legal at any non-full, non-empty occupancy, and at count==0 only push takes effect since pop requires valid).
- if_id_pc/instr/rd are a read of storage at rptr; when empty they show stale data and must be ignored (if_id_valid=0).
- rd captured as fetch_instr[11:7] at push, independent of opcode.
- mispredict_flush=1: next edge sets wptr=rptr=0, count=0; push and pop in that cycle have no effect. Storage contents not cleared.
- Reset (rst_n low, any time, asynchronous): wptr=rptr=0, count=0 → if_id_valid=0, empty=1, full=0, fetch_ready=1; storage zeroed so if_id_pc/instr/rd read 0.

## Timing
- Push-to-output latency 1 cycle: entry pushed at edge N into empty queue is valid at the head after edge N.
- Throughput 1 entry/cycle sustained when decode_ready held high and fetch_valid high.
- Flush takes effect at the edge it is sampled; first post-flush push possible in the following cycle.
- Reset deassertion: first push accepted at first rising edge with rst_n high.
- count, full, empty, fetch_ready, if_id_valid all derive from registered state only.

## Test plan
- Reset mid-operation: fill 3 entries, pull rst_n low between edges → immediately count=0, empty=1, if_id_valid=0, if_id_pc=0, fetch_ready=1.
- Fill and drain in order, DEPTH=4: push PCs 0x100,0x104,0x108,0x10C with decode_ready=0 → full=1, fetch_ready=0; 5th offer 0x110 not accepted; raise decode_ready → heads 0x100..0x10C in order, then empty.
- Full with simultaneous pop: at count=4 offer 0x110 with decode_ready=1 → pop occurs, push rejected, count=3; 0x110 accepted next cycle.
- Streaming with wrap: 10 back-to-back pushes with decode_ready=1 → one pop per cycle after 1-cycle latency, count stays 1, pointers wrap twice, no loss or reorder.
- rd extraction: push instr 0x00A00593 (addi a1,x0,10) → if_id_rd=5'd11 when at head.
- Flush with concurrent traffic: count=2, assert mispredict_flush with fetch_valid=1 and decode_ready=1 → next cycle count=0, if_id_valid=0, offered entry absent; next push appears at head one cycle later.
